hazard_ctrl_mc: RTL and testbench

HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

---
 rtl/hazard_ctrl_mc.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: operand/branch forwarding, load-use, branch and
// mult/div stalls, a fixed-latency mult/div busy tracker and a stall counter.
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MdD,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic              MdDone,
  output logic [31:0]       StallCnt
);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic        md_busy_q, md_busy_d;
  logic        md_done_q, md_done_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic rs_e_m, rs_e_w, rt_e_m, rt_e_w;
  logic rs_d_e, rt_d_e, rs_d_m, rt_d_m;
  logic lwstall, branchstall, rawstall, mdstall, stall;
  fwd_sel_e fwd_a, fwd_b;

  // Register 0 never produces a hazard regardless of the writer.
  function automatic logic src_match(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] wr,
                                     input logic              we);
    return (src != '0) && (src == wr) && we;
  endfunction

  always_comb begin
    rs_e_m = src_match(RsE, WriteRegM, RegWriteM);
    rs_e_w = src_match(RsE, WriteRegW, RegWriteW);
    rt_e_m = src_match(RtE, WriteRegM, RegWriteM);
    rt_e_w = src_match(RtE, WriteRegW, RegWriteW);
    rs_d_e = src_match(RsD, WriteRegE, RegWriteE);
    rt_d_e = src_match(RtD, WriteRegE, RegWriteE);
    rs_d_m = src_match(RsD, WriteRegM, RegWriteM);
    rt_d_m = src_match(RtD, WriteRegM, RegWriteM);
  end

  always_comb begin
    lwstall     = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    branchstall = BranchD && (rs_d_e || rt_d_e || (MemtoRegM && (rs_d_m || rt_d_m)));
    rawstall    = rs_d_e || rt_d_e || rs_d_m || rt_d_m;
    mdstall     = MdD && (md_busy_q || MdStartE);

    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (FWD_EN) begin
      if (rs_e_m)      fwd_a = FWD_M;
      else if (rs_e_w) fwd_a = FWD_W;
      if (rt_e_m)      fwd_b = FWD_M;
      else if (rt_e_w) fwd_b = FWD_W;
      ForwardAD = rs_d_m;
      ForwardBD = rt_d_m;
      stall     = lwstall || branchstall || mdstall;
    end else begin
      stall     = rawstall || mdstall;
    end
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;

  // A start only loads an idle counter; the 1->0 cycle still counts as busy,
  // so a start arriving then is dropped.
  always_comb begin
    if (md_cnt_q == '0) md_cnt_d = MdStartE ? 4'(MD_LAT) : '0;
    else                md_cnt_d = md_cnt_q - 4'd1;
    md_busy_d   = (md_cnt_d != '0);
    md_done_d   = (md_cnt_q == 4'd1);
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q    <= '0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= md_busy_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MdBusy   = md_busy_q;
  assign MdDone   = md_done_q;
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: one forwarding instance and one
// stall-only instance driven by the same stimulus.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MdD, MdStartE;

  logic [1:0]  fae, fbe, fae_n, fbe_n;
  logic        fad, fbd, fad_n, fbd_n;
  logic        stf, std, fle, stf_n, std_n, fle_n;
  logic        busy, done, busy_n, done_n;
  logic [31:0] scnt, scnt_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .MD_LAT(4), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdD(MdD), .MdStartE(MdStartE),
    .ForwardAE(fae), .ForwardBE(fbe), .ForwardAD(fad), .ForwardBD(fbd),
    .StallF(stf), .StallD(std), .FlushE(fle),
    .MdBusy(busy), .MdDone(done), .StallCnt(scnt)
  );

  hazard_ctrl_mc #(.REG_AW(5), .MD_LAT(4), .FWD_EN(1'b0)) u_dut_nf (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdD(MdD), .MdStartE(MdStartE),
    .ForwardAE(fae_n), .ForwardBE(fbe_n), .ForwardAD(fad_n), .ForwardBD(fbd_n),
    .StallF(stf_n), .StallD(std_n), .FlushE(fle_n),
    .MdBusy(busy_n), .MdDone(done_n), .StallCnt(scnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
    MdD = 1'b0; MdStartE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    clear();
    reset_n = 1'b0;
    #2;
    chk("rst_fae", 32'(fae), 32'd0);
    chk("rst_fbe", 32'(fbe), 32'd0);
    chk("rst_fad", 32'(fad), 32'd0);
    chk("rst_fbd", 32'(fbd), 32'd0);
    chk("rst_stall", {29'd0, stf, std, fle}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", scnt, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_rst_cnt", scnt, 32'd0);

    // Operand forwarding priority.
    RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd3;
    #1;
    chk("fwdA_M", 32'(fae), 32'd2);
    chk("fwdA_nf", 32'(fae_n), 32'd0);
    RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", 32'(fae), 32'd1);
    RsE = '0; WriteRegM = '0; WriteRegW = '0;
    #1;
    chk("fwdA_r0", 32'(fae), 32'd0);
    RtE = 5'd4; WriteRegW = 5'd4;
    #1;
    chk("fwdB_W", 32'(fbe), 32'd1);
    chk("fwd_nostall", 32'(std), 32'd0);
    clear();
    step();

    // Load-use stall.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    chk("lw_stall", {29'd0, stf, std, fle}, 32'd7);
    chk("lw_cnt0", scnt, 32'd0);
    chk("lw_nf", 32'(std_n), 32'd0);
    step();
    clear();
    #1;
    chk("lw_release", 32'(std), 32'd0);
    chk("lw_cnt1", scnt, 32'd1);
    MemtoRegE = 1'b1;
    #1;
    chk("lw_r0", 32'(std), 32'd0);
    clear();
    step();

    // Branch stall then forward from M.
    BranchD = 1'b1; RsD = 5'd7; RegWriteE = 1'b1; WriteRegE = 5'd7;
    #1;
    chk("br_stall", 32'(std), 32'd1);
    step();
    RegWriteE = 1'b0; WriteRegE = '0; RegWriteM = 1'b1; WriteRegM = 5'd7;
    #1;
    chk("br_nostall", 32'(std), 32'd0);
    chk("br_fad", 32'(fad), 32'd1);
    chk("br_fbd", 32'(fbd), 32'd0);
    MemtoRegM = 1'b1;
    #1;
    chk("br_ldM", 32'(std), 32'd1);
    MemtoRegM = 1'b0;
    clear();
    step();
    chk("br_cnt", scnt, 32'd2);

    // Stall-only configuration.
    RsD = 5'd2; RsE = 5'd2; RegWriteM = 1'b1; WriteRegM = 5'd2;
    #1;
    chk("nf_raw", 32'(std_n), 32'd1);
    chk("nf_fwd", {26'd0, fae_n, fbe_n, fad_n, fbd_n}, 32'd0);
    chk("fw_fae", 32'(fae), 32'd2);
    chk("fw_nostall", 32'(std), 32'd0);
    WriteRegM = '0;
    #1;
    chk("nf_noraw", 32'(std_n), 32'd0);
    RtD = 5'd6; RegWriteE = 1'b1; WriteRegE = 5'd6;
    #1;
    chk("nf_rawE", 32'(std_n), 32'd1);
    clear();
    step();

    // Single mult/div with a dependent MdD in decode.
    MdStartE = 1'b1; MdD = 1'b1;
    #1;
    chk("md_c0_stall", 32'(std), 32'd1);
    chk("md_c0_busy", 32'(busy), 32'd0);
    step();
    MdStartE = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("md_c%0d_busy", c), 32'(busy), 32'd1);
      chk($sformatf("md_c%0d_done", c), 32'(done), 32'd0);
      chk($sformatf("md_c%0d_stall", c), 32'(std), 32'd1);
      step();
    end
    chk("md_c5_busy", 32'(busy), 32'd0);
    chk("md_c5_done", 32'(done), 32'd1);
    chk("md_c5_stall", 32'(std), 32'd0);
    chk("md_cnt", scnt, 32'd7);
    MdD = 1'b0;
    step();
    chk("md_c6_done", 32'(done), 32'd0);

    // Start held high: ignored while busy and in the 1->0 cycle.
    MdStartE = 1'b1;
    step();
    chk("hold_c1_busy", 32'(busy), 32'd1);
    repeat (3) step();
    chk("hold_c4_busy", 32'(busy), 32'd1);
    step();
    chk("hold_c5_busy", 32'(busy), 32'd0);
    chk("hold_c5_done", 32'(done), 32'd1);
    step();
    chk("hold_reload", 32'(busy), 32'd1);
    chk("hold_c6_done", 32'(done), 32'd0);
    chk("hold_cnt", scnt, 32'd7);

    // Reset in cycle 2 of that multiply.
    MdStartE = 1'b0; MdD = 1'b1;
    #1;
    chk("ab_stall", 32'(std), 32'd1);
    step();
    chk("ab_cnt_pre", scnt, 32'd8);
    reset_n = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_cnt", scnt, 32'd0);
    chk("ab_stall_rst", 32'(std), 32'd0);
    repeat (2) step();
    chk("ab_done_rst", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    MdD = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("ab_post%0d", c), {30'd0, busy, done}, 32'd0);
    end

    // Full-latency count after reset.
    MdStartE = 1'b1;
    step();
    MdStartE = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("re_c%0d", c), {30'd0, busy, done}, 32'd2);
      step();
    end
    chk("re_c5", {30'd0, busy, done}, 32'd1);
    chk("re_cnt", scnt, 32'd0);

    // Stall counter saturation.
    @(negedge clk);
    force u_dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.stall_cnt_q;
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    chk("sat_pre", scnt, 32'hFFFF_FFFE);
    step();
    chk("sat_max", scnt, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", scnt, 32'hFFFF_FFFF);
    clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
